ibus_dbus_arbiter: RTL and testbench
====================================

Name: ibus_dbus_arbiter

Overview:
- Shares a single memory port between the core's instruction bus (iBus) and data bus (dBus).
- Arbitrates commands, with dBus priority and a starvation guard for iBus.
- Tracks up to MAX_OUTSTANDING in-order transactions and routes each memory response back to the bus that issued it.
- Sits between the riscv core and the unified memory/interconnect.

Parameters:
- MAX_OUTSTANDING, 4, depth of the in-order source-tag FIFO (power of two, ≥2).
- STARVE_LIMIT, 8, consecutive dBus wins while iBus waits before iBus is forced to win (1..255).

Ports:
- clk  in  1  clock
- rstf  in  1  reset. Asynchronous, active-low.
- iBus_cmd_valid  in  1  instruction fetch request
- iBus_cmd_ready  out  1  fetch accepted this cycle
- iBus_cmd_payload_pc  in  32  fetch address
- iBus_rsp_ready  out  1  fetch response valid
- iBus_rsp_err  out  1  fetch response error
- iBus_rsp_instr  out  32  fetched instruction
- dBus_cmd_valid  in  1  data request
- dBus_cmd_ready  out  1  data request accepted this cycle
- dBus_cmd_payload_addr  in  32  data address
- dBus_cmd_payload_data  in  32  write data
- dBus_cmd_payload_size  in  4  byte mask
- dBus_cmd_payload_wr  in  1  1 = write, 0 = read
- dBus_rsp_valid  out  1  data response valid
- dBus_rsp_data  out  32  read data
- dBus_rsp_error  out  1  data response error
- mem_cmd_valid  out  1  command to memory
- mem_cmd_ready  in  1  memory accepts command
- mem_cmd_addr  out  32  command address
- mem_cmd_data  out  32  write data
- mem_cmd_mask  out  4  byte mask
- mem_cmd_wr  out  1  write flag
- mem_rsp_valid  in  1  response beat
- mem_rsp_data  in  32  response data
- mem_rsp_err  in  1  response error
- protocol_err  out  1  sticky: response received with no outstanding transaction

Behaviour:
- Reset (rstf low, async):
  - State goes to IDLE.
  - Tag FIFO is emptied (count = 0, pointers = 0).
  - Starvation counter = 0.
  - protocol_err = 0.
  - All *_ready, *_valid and mem_cmd_valid outputs = 0.
  - Payload outputs = 0.
- Reset mid-operation: in-flight commands are abandoned. A stray mem_rsp_valid after reset hits an empty FIFO and sets protocol_err; this is required behaviour.
- FSM states: IDLE, GNT_I, GNT_D. The grant is registered.
- IDLE:
  - If count == MAX_OUTSTANDING, stay in IDLE and grant nothing.
  - Otherwise pick a winner:
    - iBus wins if (iBus_cmd_valid and starve_cnt ≥ STARVE_LIMIT) or (iBus_cmd_valid and !dBus_cmd_valid).
    - Else dBus wins if dBus_cmd_valid.
  - Move to GNT_I or GNT_D accordingly.
- GNT_x:
  - mem_cmd_valid = 1, with payload muxed combinationally from bus x.
  - For iBus: mask = 4'b1111, wr = 0, data = 0.
  - Payload must stay stable while mem_cmd_valid && !mem_cmd_ready.
  - On mem_cmd_ready:
    - x_cmd_ready = 1 for exactly that cycle.
    - Push tag x (0 = I, 1 = D) into the FIFO.
    - Return to IDLE.
  - Minimum issue interval is 2 cycles. Latency from request to mem_cmd_valid is 1 cycle.
- Requesters hold valid and payload until ready. A grant is never revoked once it is issued.
- Starvation counter, evaluated in IDLE on a grant:
  - dBus granted while iBus_cmd_valid: increment, saturating at STARVE_LIMIT.
  - iBus granted: clear to 0.
  - Otherwise: hold.
- Every command, read or write, yields exactly one mem_rsp_valid beat, in order.
- Response routing is combinational, zero cycle:
  - Head tag I: iBus_rsp_ready = mem_rsp_valid; iBus_rsp_instr = mem_rsp_data; iBus_rsp_err = mem_rsp_err.
  - Head tag D: dBus_rsp_valid, dBus_rsp_data and dBus_rsp_error are driven likewise.
  - The inactive bus sees valid = 0 and data = 0.
  - The FIFO pops on mem_rsp_valid when non-empty.
- Push and pop in the same cycle: count unchanged, pointers both advance.
- Full (count == MAX_OUTSTANDING) blocks new grants in IDLE, even if a pop occurs that cycle. A pending GNT_x state is only entered when the FIFO is not full, so a push never overflows.
- mem_rsp_valid with the FIFO empty: the beat is dropped, no bus response is driven, and protocol_err is set. It stays set until reset.
- Pointers wrap modulo MAX_OUTSTANDING.

Test Plan:
- Only iBus_cmd_valid=1, pc=0x100, mem_cmd_ready=1 → mem_cmd_valid in cycle 1 with addr 0x100, mask 0xF, wr 0, and iBus_cmd_ready in the same cycle. mem_rsp data 0x00000013 → iBus_rsp_ready=1, instr=0x13, dBus_rsp_valid=0.
- Both valid continuously, STARVE_LIMIT=8, instant memory → 8 dBus grants, then 1 iBus grant, then the counter clears and the pattern repeats.
- mem_rsp held off, 5 dBus reads issued (MAX_OUTSTANDING=4) → exactly 4 accepted and the 5th stalls. After one response, the 5th issues 2 cycles later.
- Interleaved I, D, I commands; responses 0xA, 0xB, 0xC with err on the 2nd → routed to I, D (dBus_rsp_error=1), I in order.
- mem_rsp_valid with nothing outstanding → no bus response, protocol_err=1 and sticky. After rstf pulse, protocol_err=0.
- rstf asserted while in GNT_D with 2 outstanding → all outputs 0 immediately (async). After release, a new iBus fetch issues normally.

Source files
------------

// File: rtl/ibus_dbus_arbiter.sv
// ibus_dbus_arbiter: shares one memory port between the core's iBus and dBus.
// Ports: clk/rstf; iBus cmd+rsp; dBus cmd+rsp; unified mem cmd+rsp; protocol_err.
module ibus_dbus_arbiter #(
   parameter int MAX_OUTSTANDING = 4,
   parameter int STARVE_LIMIT    = 8
) (
   input  logic        clk,
   input  logic        rstf,
   input  logic        iBus_cmd_valid,
   output logic        iBus_cmd_ready,
   input  logic [31:0] iBus_cmd_payload_pc,
   output logic        iBus_rsp_ready,
   output logic        iBus_rsp_err,
   output logic [31:0] iBus_rsp_instr,
   input  logic        dBus_cmd_valid,
   output logic        dBus_cmd_ready,
   input  logic [31:0] dBus_cmd_payload_addr,
   input  logic [31:0] dBus_cmd_payload_data,
   input  logic [3:0]  dBus_cmd_payload_size,
   input  logic        dBus_cmd_payload_wr,
   output logic        dBus_rsp_valid,
   output logic [31:0] dBus_rsp_data,
   output logic        dBus_rsp_error,
   output logic        mem_cmd_valid,
   input  logic        mem_cmd_ready,
   output logic [31:0] mem_cmd_addr,
   output logic [31:0] mem_cmd_data,
   output logic [3:0]  mem_cmd_mask,
   output logic        mem_cmd_wr,
   input  logic        mem_rsp_valid,
   input  logic [31:0] mem_rsp_data,
   input  logic        mem_rsp_err,
   output logic        protocol_err
);

   localparam int PW = $clog2(MAX_OUTSTANDING);
   localparam int CW = PW + 1;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] GNT_I = 2'd1;
   localparam logic [1:0] GNT_D = 2'd2;

   logic [1:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [PW-1:0] wptr_q, rptr_q;
   logic [MAX_OUTSTANDING-1:0] tags_q;
   logic [7:0]    starve_q, starve_d;
   logic          perr_q;

   logic full, empty, i_win, gnt_i, gnt_d;
   logic push, pop, head_d, rsp_i, rsp_d;

   assign full  = (cnt_q == CW'(MAX_OUTSTANDING));
   assign empty = (cnt_q == '0);
   assign gnt_i = (state_q == GNT_I);
   assign gnt_d = (state_q == GNT_D);

   // iBus takes the port when dBus is idle or iBus has waited too long
   assign i_win = iBus_cmd_valid &&
                  ((starve_q >= 8'(STARVE_LIMIT)) || !dBus_cmd_valid);

   assign push   = (gnt_i || gnt_d) && mem_cmd_ready;
   assign pop    = mem_rsp_valid && !empty;
   assign head_d = tags_q[rptr_q];

   always_comb begin
      state_d  = state_q;
      starve_d = starve_q;
      unique case (state_q)
         IDLE: begin
            if (!full) begin
               if (i_win) begin
                  state_d  = GNT_I;
                  starve_d = '0;
               end else if (dBus_cmd_valid) begin
                  state_d = GNT_D;
                  if (iBus_cmd_valid && (starve_q < 8'(STARVE_LIMIT)))
                     starve_d = starve_q + 8'd1;
               end
            end
         end
         GNT_I, GNT_D: begin
            if (mem_cmd_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      cnt_d = cnt_q;
      unique case ({push, pop})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or negedge rstf) begin
      if (!rstf) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         wptr_q   <= '0;
         rptr_q   <= '0;
         tags_q   <= '0;
         starve_q <= '0;
         perr_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         starve_q <= starve_d;
         if (push) begin
            tags_q[wptr_q] <= gnt_d;
            wptr_q         <= wptr_q + PW'(1);
         end
         if (pop) rptr_q <= rptr_q + PW'(1);
         // a beat with nothing outstanding is dropped and flagged
         if (mem_rsp_valid && empty) perr_q <= 1'b1;
      end
   end

   always_comb begin
      mem_cmd_valid = gnt_i || gnt_d;
      mem_cmd_addr  = '0;
      mem_cmd_data  = '0;
      mem_cmd_mask  = '0;
      mem_cmd_wr    = 1'b0;
      if (gnt_i) begin
         mem_cmd_addr = iBus_cmd_payload_pc;
         mem_cmd_mask = 4'b1111;
      end else if (gnt_d) begin
         mem_cmd_addr = dBus_cmd_payload_addr;
         mem_cmd_data = dBus_cmd_payload_data;
         mem_cmd_mask = dBus_cmd_payload_size;
         mem_cmd_wr   = dBus_cmd_payload_wr;
      end
   end

   assign iBus_cmd_ready = gnt_i && mem_cmd_ready;
   assign dBus_cmd_ready = gnt_d && mem_cmd_ready;

   assign rsp_i = pop && !head_d;
   assign rsp_d = pop && head_d;

   assign iBus_rsp_ready = rsp_i;
   assign iBus_rsp_instr = rsp_i ? mem_rsp_data : '0;
   assign iBus_rsp_err   = rsp_i && mem_rsp_err;
   assign dBus_rsp_valid = rsp_d;
   assign dBus_rsp_data  = rsp_d ? mem_rsp_data : '0;
   assign dBus_rsp_error = rsp_d && mem_rsp_err;

   assign protocol_err = perr_q;

endmodule

// File: tb/tb_ibus_dbus_arbiter.sv
// tb_ibus_dbus_arbiter: directed vector table plus hand sequences for
// starvation, FIFO full, and asynchronous reset behaviour.
module tb_ibus_dbus_arbiter;

   logic        clk = 1'b0;
   logic        rstf;
   logic        iBus_cmd_valid, iBus_cmd_ready;
   logic [31:0] iBus_cmd_payload_pc;
   logic        iBus_rsp_ready, iBus_rsp_err;
   logic [31:0] iBus_rsp_instr;
   logic        dBus_cmd_valid, dBus_cmd_ready;
   logic [31:0] dBus_cmd_payload_addr, dBus_cmd_payload_data;
   logic [3:0]  dBus_cmd_payload_size;
   logic        dBus_cmd_payload_wr;
   logic        dBus_rsp_valid, dBus_rsp_error;
   logic [31:0] dBus_rsp_data;
   logic        mem_cmd_valid, mem_cmd_ready, mem_cmd_wr;
   logic [31:0] mem_cmd_addr, mem_cmd_data;
   logic [3:0]  mem_cmd_mask;
   logic        mem_rsp_valid, mem_rsp_err;
   logic [31:0] mem_rsp_data;
   logic        protocol_err;

   always #5 clk = ~clk;

   ibus_dbus_arbiter #(.MAX_OUTSTANDING(4), .STARVE_LIMIT(8)) dut (
      .clk(clk), .rstf(rstf),
      .iBus_cmd_valid(iBus_cmd_valid), .iBus_cmd_ready(iBus_cmd_ready),
      .iBus_cmd_payload_pc(iBus_cmd_payload_pc),
      .iBus_rsp_ready(iBus_rsp_ready), .iBus_rsp_err(iBus_rsp_err),
      .iBus_rsp_instr(iBus_rsp_instr),
      .dBus_cmd_valid(dBus_cmd_valid), .dBus_cmd_ready(dBus_cmd_ready),
      .dBus_cmd_payload_addr(dBus_cmd_payload_addr),
      .dBus_cmd_payload_data(dBus_cmd_payload_data),
      .dBus_cmd_payload_size(dBus_cmd_payload_size),
      .dBus_cmd_payload_wr(dBus_cmd_payload_wr),
      .dBus_rsp_valid(dBus_rsp_valid), .dBus_rsp_data(dBus_rsp_data),
      .dBus_rsp_error(dBus_rsp_error),
      .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready),
      .mem_cmd_addr(mem_cmd_addr), .mem_cmd_data(mem_cmd_data),
      .mem_cmd_mask(mem_cmd_mask), .mem_cmd_wr(mem_cmd_wr),
      .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
      .mem_rsp_err(mem_rsp_err), .protocol_err(protocol_err)
   );

   typedef struct {
      logic        iv;  logic [31:0] pc;
      logic        dv;  logic [31:0] da; logic [31:0] dd;
      logic [3:0]  ds;  logic        dw;
      logic        mcr; logic        mrv; logic [31:0] mrd; logic mre;
      logic        mcv; logic [31:0] ma;  logic [31:0] md;
      logic [3:0]  mm;  logic        mw;
      logic        ir;  logic        dr;
      logic        irv; logic [31:0] ii;  logic ie;
      logic        drv; logic [31:0] ddo; logic de;
      logic        pe;
   } vec_t;

   vec_t tbl [15];
   int   errors = 0;
   int   checks = 0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      iBus_cmd_valid = 0; iBus_cmd_payload_pc = 0;
      dBus_cmd_valid = 0; dBus_cmd_payload_addr = 0;
      dBus_cmd_payload_data = 0; dBus_cmd_payload_size = 0;
      dBus_cmd_payload_wr = 0; mem_cmd_ready = 0;
      mem_rsp_valid = 0; mem_rsp_data = 0; mem_rsp_err = 0;
   endtask

   task automatic do_reset();
      rstf = 1'b0;
      @(posedge clk);
      #1;
      rstf = 1'b1;
   endtask

   initial begin
      int acc;
      int g;
      bit pend;
      bit exp_i;

      //      iv pc      dv da      dd     ds   dw mcr mrv mrd      mre
      //      mcv ma     md     mm   mw ir dr irv ii     ie drv ddo  de pe
      tbl[0]  = '{1,32'h100,0,0,0,0,0, 1,0,0,0,
                  0,0,0,0,0, 0,0, 0,0,0, 0,0,0, 0};
      tbl[1]  = '{1,32'h100,0,0,0,0,0, 1,0,0,0,
                  1,32'h100,0,4'hF,0, 1,0, 0,0,0, 0,0,0, 0};
      tbl[2]  = '{0,0,0,0,0,0,0, 1,1,32'h13,0,
                  0,0,0,0,0, 0,0, 1,32'h13,0, 0,0,0, 0};
      tbl[3]  = '{1,32'h200,0,0,0,0,0, 1,0,0,0,
                  0,0,0,0,0, 0,0, 0,0,0, 0,0,0, 0};
      tbl[4]  = '{1,32'h200,1,32'h300,32'h55,4'h3,1, 1,0,0,0,
                  1,32'h200,0,4'hF,0, 1,0, 0,0,0, 0,0,0, 0};
      tbl[5]  = '{0,0,1,32'h300,32'h55,4'h3,1, 1,0,0,0,
                  0,0,0,0,0, 0,0, 0,0,0, 0,0,0, 0};
      tbl[6]  = '{1,32'h204,1,32'h300,32'h55,4'h3,1, 1,0,0,0,
                  1,32'h300,32'h55,4'h3,1, 0,1, 0,0,0, 0,0,0, 0};
      tbl[7]  = '{1,32'h204,0,0,0,0,0, 1,0,0,0,
                  0,0,0,0,0, 0,0, 0,0,0, 0,0,0, 0};
      tbl[8]  = '{1,32'h204,0,0,0,0,0, 1,0,0,0,
                  1,32'h204,0,4'hF,0, 1,0, 0,0,0, 0,0,0, 0};
      tbl[9]  = '{0,0,0,0,0,0,0, 0,1,32'hA,0,
                  0,0,0,0,0, 0,0, 1,32'hA,0, 0,0,0, 0};
      tbl[10] = '{0,0,0,0,0,0,0, 0,1,32'hB,1,
                  0,0,0,0,0, 0,0, 0,0,0, 1,32'hB,1, 0};
      tbl[11] = '{0,0,0,0,0,0,0, 0,1,32'hC,0,
                  0,0,0,0,0, 0,0, 1,32'hC,0, 0,0,0, 0};
      tbl[12] = '{0,0,0,0,0,0,0, 0,1,32'hDEAD,1,
                  0,0,0,0,0, 0,0, 0,0,0, 0,0,0, 0};
      tbl[13] = '{0,0,0,0,0,0,0, 0,0,0,0,
                  0,0,0,0,0, 0,0, 0,0,0, 0,0,0, 1};
      tbl[14] = '{0,0,0,0,0,0,0, 0,0,0,0,
                  0,0,0,0,0, 0,0, 0,0,0, 0,0,0, 1};

      clear_inputs();
      rstf = 1'b0;
      #3;
      chk("rst_mcv", {31'b0, mem_cmd_valid}, 0);
      chk("rst_ir", {31'b0, iBus_cmd_ready}, 0);
      chk("rst_dr", {31'b0, dBus_cmd_ready}, 0);
      chk("rst_addr", mem_cmd_addr, 0);
      chk("rst_mask", {28'b0, mem_cmd_mask}, 0);
      chk("rst_pe", {31'b0, protocol_err}, 0);
      @(posedge clk);
      #1;
      rstf = 1'b1;

      for (int k = 0; k < 15; k++) begin
         iBus_cmd_valid        = tbl[k].iv;
         iBus_cmd_payload_pc   = tbl[k].pc;
         dBus_cmd_valid        = tbl[k].dv;
         dBus_cmd_payload_addr = tbl[k].da;
         dBus_cmd_payload_data = tbl[k].dd;
         dBus_cmd_payload_size = tbl[k].ds;
         dBus_cmd_payload_wr   = tbl[k].dw;
         mem_cmd_ready         = tbl[k].mcr;
         mem_rsp_valid         = tbl[k].mrv;
         mem_rsp_data          = tbl[k].mrd;
         mem_rsp_err           = tbl[k].mre;
         #1;
         chk($sformatf("v%0d_mcv", k), {31'b0, mem_cmd_valid}, {31'b0, tbl[k].mcv});
         chk($sformatf("v%0d_addr", k), mem_cmd_addr, tbl[k].ma);
         chk($sformatf("v%0d_data", k), mem_cmd_data, tbl[k].md);
         chk($sformatf("v%0d_mask", k), {28'b0, mem_cmd_mask}, {28'b0, tbl[k].mm});
         chk($sformatf("v%0d_wr", k), {31'b0, mem_cmd_wr}, {31'b0, tbl[k].mw});
         chk($sformatf("v%0d_ir", k), {31'b0, iBus_cmd_ready}, {31'b0, tbl[k].ir});
         chk($sformatf("v%0d_dr", k), {31'b0, dBus_cmd_ready}, {31'b0, tbl[k].dr});
         chk($sformatf("v%0d_irv", k), {31'b0, iBus_rsp_ready}, {31'b0, tbl[k].irv});
         chk($sformatf("v%0d_ii", k), iBus_rsp_instr, tbl[k].ii);
         chk($sformatf("v%0d_ie", k), {31'b0, iBus_rsp_err}, {31'b0, tbl[k].ie});
         chk($sformatf("v%0d_drv", k), {31'b0, dBus_rsp_valid}, {31'b0, tbl[k].drv});
         chk($sformatf("v%0d_ddo", k), dBus_rsp_data, tbl[k].ddo);
         chk($sformatf("v%0d_de", k), {31'b0, dBus_rsp_error}, {31'b0, tbl[k].de});
         chk($sformatf("v%0d_pe", k), {31'b0, protocol_err}, {31'b0, tbl[k].pe});
         tick();
      end

      // sticky error clears only through reset
      clear_inputs();
      do_reset();
      #1;
      chk("pe_cleared", {31'b0, protocol_err}, 0);

      // stalled grant: payload holds and dBus cannot revoke it
      iBus_cmd_valid = 1; iBus_cmd_payload_pc = 32'h500;
      tick();
      for (int c = 0; c < 3; c++) begin
         if (c == 1) begin
            dBus_cmd_valid = 1; dBus_cmd_payload_addr = 32'h600;
            dBus_cmd_payload_wr = 0; dBus_cmd_payload_size = 4'hF;
         end
         #1;
         chk("stall_mcv", {31'b0, mem_cmd_valid}, 1);
         chk("stall_addr", mem_cmd_addr, 32'h500);
         chk("stall_ir", {31'b0, iBus_cmd_ready}, 0);
         chk("stall_dr", {31'b0, dBus_cmd_ready}, 0);
         tick();
      end
      mem_cmd_ready = 1;
      #1;
      chk("stall_accept", {31'b0, iBus_cmd_ready}, 1);
      tick();
      iBus_cmd_valid = 0;
      tick();
      #1;
      chk("stall_d_addr", mem_cmd_addr, 32'h600);
      chk("stall_d_acc", {31'b0, dBus_cmd_ready}, 1);
      tick();
      dBus_cmd_valid = 0;
      mem_rsp_valid = 1; mem_rsp_data = 32'h11;
      #1;
      chk("stall_rsp_i", {31'b0, iBus_rsp_ready}, 1);
      tick();
      mem_rsp_data = 32'h22;
      #1;
      chk("stall_rsp_d", dBus_rsp_data, 32'h22);
      tick();
      mem_rsp_valid = 0;

      // starvation guard: 8 dBus wins then one iBus win, repeated
      clear_inputs();
      do_reset();
      iBus_cmd_valid = 1; iBus_cmd_payload_pc = 32'h700;
      dBus_cmd_valid = 1; dBus_cmd_payload_addr = 32'h800;
      mem_cmd_ready = 1;
      g = 0; pend = 0;
      for (int c = 0; c < 80 && g < 18; c++) begin
         mem_rsp_valid = pend;
         #1;
         if (mem_cmd_valid) begin
            exp_i = (g % 9 == 8);
            chk($sformatf("starve_g%0d", g), {31'b0, iBus_cmd_ready},
                {31'b0, exp_i});
            g++;
            pend = 1;
         end else begin
            pend = 0;
         end
         tick();
      end
      chk("starve_count", g, 18);
      iBus_cmd_valid = 0; dBus_cmd_valid = 0;
      mem_rsp_valid = pend;
      tick();
      mem_rsp_valid = 0;

      // FIFO full: exactly 4 accepted, 5th issues 2 cycles after a response
      clear_inputs();
      do_reset();
      dBus_cmd_valid = 1; dBus_cmd_payload_addr = 32'h900;
      mem_cmd_ready = 1;
      acc = 0;
      for (int c = 0; c < 20; c++) begin
         #1;
         if (dBus_cmd_ready) acc++;
         tick();
      end
      chk("full_accepted", acc, 4);
      mem_rsp_valid = 1; mem_rsp_data = 32'h99;
      #1;
      chk("full_rsp", {31'b0, dBus_rsp_valid}, 1);
      chk("full_blk0", {31'b0, mem_cmd_valid}, 0);
      tick();
      mem_rsp_valid = 0;
      #1;
      chk("full_blk1", {31'b0, mem_cmd_valid}, 0);
      tick();
      #1;
      chk("full_issue", {31'b0, dBus_cmd_ready}, 1);
      tick();
      dBus_cmd_valid = 0;

      // async reset while GNT_D is pending with 2 outstanding
      clear_inputs();
      do_reset();
      dBus_cmd_valid = 1; dBus_cmd_payload_addr = 32'hA00;
      dBus_cmd_payload_size = 4'hF; dBus_cmd_payload_wr = 1;
      mem_cmd_ready = 1;
      acc = 0;
      for (int c = 0; c < 10 && acc < 2; c++) begin
         #1;
         if (dBus_cmd_ready) acc++;
         tick();
      end
      chk("ar_acc", acc, 2);
      mem_cmd_ready = 0;
      tick();
      #1;
      chk("ar_pre_gnt", {31'b0, mem_cmd_valid}, 1);
      #1;
      rstf = 1'b0;
      #1;
      chk("ar_mcv", {31'b0, mem_cmd_valid}, 0);
      chk("ar_addr", mem_cmd_addr, 0);
      chk("ar_mask", {28'b0, mem_cmd_mask}, 0);
      chk("ar_wr", {31'b0, mem_cmd_wr}, 0);
      dBus_cmd_valid = 0;
      iBus_cmd_valid = 1; iBus_cmd_payload_pc = 32'h400;
      mem_cmd_ready = 1;
      tick();
      rstf = 1'b1;
      #1;
      chk("ar_idle", {31'b0, mem_cmd_valid}, 0);
      tick();
      #1;
      chk("ar_fetch_addr", mem_cmd_addr, 32'h400);
      chk("ar_fetch_ir", {31'b0, iBus_cmd_ready}, 1);
      tick();
      iBus_cmd_valid = 0;
      mem_rsp_valid = 1; mem_rsp_data = 32'h77;
      #1;
      chk("ar_rsp", iBus_rsp_instr, 32'h77);
      chk("ar_rsp_d", {31'b0, dBus_rsp_valid}, 0);
      chk("ar_pe", {31'b0, protocol_err}, 0);
      tick();
      mem_rsp_valid = 0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
